// File: rtl/scram_tx_sequencer.sv
// Transmit sequencer in front of a 64b unrolled scrambler: forces idle blocks
// after reset, fills idle when the user has no data, and opens periodic gearbox
// gap cycles. A word accepted in cycle N appears on blk_out in cycle N+1; the
// block has no backpressure input, and the user is held off only by tx_ready
// during INIT, reset and gap cycles.
//
// Ports:
//   clk, sclr              clock and synchronous active-high reset
//   tx_data/ctrl/valid     user block stream; tx_ready is combinational
//   scram_arst/ena/din     drive the external scrambler (all combinational)
//   scram_dout             scrambler's registered output
//   blk_out/blk_valid      66-bit block {scrambled payload, header} to the gearbox
//   idle_ins               pulse: an idle block was inserted while in RUN
module scram_tx_sequencer #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    INIT_IDLES = 16,
  parameter int                    GAP_PERIOD = 33,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(64'h0000_0000_0000_001e)
) (
  input  logic                  clk,
  input  logic                  sclr,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ctrl,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  scram_arst,
  output logic                  scram_ena,
  output logic [DATA_WIDTH-1:0] scram_din,
  input  logic [DATA_WIDTH-1:0] scram_dout,
  output logic [DATA_WIDTH+1:0] blk_out,
  output logic                  blk_valid,
  output logic                  idle_ins
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [15:0] INIT_LAST = 16'(INIT_IDLES - 1);
  // When gaps are disabled GAP_LAST is never compared (GAP_EN gates it).
  localparam logic [15:0] GAP_LAST  = 16'(GAP_PERIOD - 1);
  localparam bit          GAP_EN    = (GAP_PERIOD != 0);

  localparam logic [1:0] HDR_CTRL = 2'b10;
  localparam logic [1:0] HDR_DATA = 2'b01;

  state_t      state, state_nxt;
  logic [15:0] init_cnt, init_nxt;
  logic [15:0] gap_cnt, gap_nxt;
  logic [1:0]  hdr_q, hdr_nxt;
  logic        idle_nxt;
  logic        gap_now;

  always_comb begin
    state_nxt = state;
    init_nxt  = init_cnt;
    gap_nxt   = gap_cnt;
    gap_now   = 1'b0;
    tx_ready  = 1'b0;
    scram_ena = 1'b0;
    scram_din = IDLE_WORD;
    hdr_nxt   = HDR_CTRL;
    idle_nxt  = 1'b0;

    case (state)
      ST_INIT: begin
        // Forced idles are not counted as insertions on idle_ins.
        scram_ena = 1'b1;
        init_nxt  = init_cnt + 16'd1;
        if (init_cnt == INIT_LAST) begin
          state_nxt = ST_RUN;
          init_nxt  = '0;
        end
      end
      ST_RUN: begin
        gap_now = GAP_EN && (gap_cnt == GAP_LAST);
        if (GAP_EN) begin
          gap_nxt = gap_now ? 16'd0 : gap_cnt + 16'd1;
        end
        tx_ready  = !gap_now;
        scram_ena = !gap_now;
        if (!gap_now) begin
          if (tx_valid) begin
            scram_din = tx_data;
            hdr_nxt   = tx_ctrl ? HDR_CTRL : HDR_DATA;
          end else begin
            idle_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = ST_INIT;
    endcase

    // Reset wins over everything: nothing accepted, scrambler frozen while it reseeds.
    if (sclr) begin
      tx_ready  = 1'b0;
      scram_ena = 1'b0;
      idle_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      gap_cnt   <= '0;
      hdr_q     <= 2'b00;
      blk_valid <= 1'b0;
      idle_ins  <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_nxt;
      gap_cnt   <= gap_nxt;
      // Header bypasses the scrambler; registering it here lines it up with
      // the scrambler's one-cycle output register.
      if (scram_ena) begin
        hdr_q <= hdr_nxt;
      end
      blk_valid <= scram_ena;
      idle_ins  <= idle_nxt;
    end
  end

  assign scram_arst = sclr;
  assign blk_out    = {scram_dout, hdr_q};

endmodule

// File: tb/tb_scram_tx_sequencer.sv
module tb_scram_tx_sequencer;

  localparam int          DW         = 64;
  localparam int          INIT_IDLES = 4;
  localparam int          GAP_PERIOD = 33;
  localparam logic [63:0] IDLE       = 64'h0000_0000_0000_001e;

  logic          clk = 1'b0;
  logic          sclr;
  logic [DW-1:0] tx_data;
  logic          tx_ctrl;
  logic          tx_valid;
  logic          tx_ready;
  logic          scram_arst;
  logic          scram_ena;
  logic [DW-1:0] scram_din;
  logic [DW-1:0] scram_dout;
  logic [DW+1:0] blk_out;
  logic          blk_valid;
  logic          idle_ins;

  always #5 clk = ~clk;

  scram_tx_sequencer #(
    .DATA_WIDTH(DW),
    .INIT_IDLES(INIT_IDLES),
    .GAP_PERIOD(GAP_PERIOD),
    .IDLE_WORD (IDLE)
  ) dut (
    .clk       (clk),
    .sclr      (sclr),
    .tx_data   (tx_data),
    .tx_ctrl   (tx_ctrl),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .scram_arst(scram_arst),
    .scram_ena (scram_ena),
    .scram_din (scram_din),
    .scram_dout(scram_dout),
    .blk_out   (blk_out),
    .blk_valid (blk_valid),
    .idle_ins  (idle_ins)
  );

  // Self-synchronous x^58+x^39+1 scrambler, bit 0 first, all-ones seed.
  function automatic logic [121:0] scr_fn(input logic [63:0] din, input logic [57:0] s);
    logic [63:0] o;
    logic [57:0] st;
    st = s;
    for (int i = 0; i < 64; i++) begin
      o[i] = din[i] ^ st[38] ^ st[57];
      st   = {st[56:0], o[i]};
    end
    return {o, st};
  endfunction

  function automatic logic [121:0] dscr_fn(input logic [63:0] din, input logic [57:0] s);
    logic [63:0] o;
    logic [57:0] st;
    st = s;
    for (int i = 0; i < 64; i++) begin
      o[i] = din[i] ^ st[38] ^ st[57];
      st   = {st[56:0], din[i]};
    end
    return {o, st};
  endfunction

  // Scrambler instance stand-in: registered output, reseeds on scram_arst.
  logic [57:0] sc_s;
  always @(posedge clk) begin
    if (scram_arst) begin
      sc_s       <= '1;
      scram_dout <= '0;
    end else if (scram_ena) begin
      {scram_dout, sc_s} <= scr_fn(scram_din, sc_s);
    end
  end

  int vectors     = 0;
  int miscompares = 0;
  int n_cmp       = 0;

  // Reference model: blocks sent in INIT so far, cycles spent in RUN so far.
  int m_init = 0;
  int m_run  = 0;
  logic [57:0] ds;

  // User-side word holder.
  bit          have_word = 0;
  logic [63:0] w_data;
  logic        w_ctrl;
  bit          last_xfer;
  logic        obs_rdy;

  task automatic chk(input string tag, input logic [65:0] exp, input logic [65:0] got);
    n_cmp++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit gap_next();
    return (m_init >= INIT_IDLES) && (GAP_PERIOD != 0) && ((m_run % GAP_PERIOD) == GAP_PERIOD - 1);
  endfunction

  task automatic step(input logic r, input logic v, input logic c, input logic [63:0] d);
    logic        e_rdy, e_ena, e_idle, gap;
    logic [1:0]  e_hdr;
    logic [63:0] e_din;
    logic [121:0] dd;
    sclr = r; tx_valid = v; tx_ctrl = c; tx_data = d;
    vectors++;
    #2;
    e_rdy = 1'b0; e_ena = 1'b0; e_idle = 1'b0; e_hdr = 2'b10; e_din = IDLE; gap = 1'b0;
    if (r) begin
      m_init = 0;
      m_run  = 0;
    end else if (m_init < INIT_IDLES) begin
      e_ena = 1'b1;
      m_init++;
    end else begin
      gap = gap_next();
      m_run++;
      e_rdy = !gap;
      e_ena = !gap;
      if (!gap && v) begin
        e_din = d;
        e_hdr = c ? 2'b10 : 2'b01;
      end else if (!gap) begin
        e_idle = 1'b1;
      end
    end
    chk("tx_ready", 66'(e_rdy), 66'(tx_ready));
    chk("scram_ena", 66'(e_ena), 66'(scram_ena));
    chk("scram_arst", 66'(r), 66'(scram_arst));
    if (e_ena) chk("scram_din", 66'(e_din), 66'(scram_din));
    obs_rdy   = tx_ready;
    last_xfer = v && tx_ready;
    @(posedge clk);
    #1;
    chk("blk_valid", 66'(e_ena), 66'(blk_valid));
    chk("idle_ins", 66'(e_idle), 66'(idle_ins));
    if (r) chk("blk_out_rst", 66'd0, blk_out);
    if (blk_valid) begin
      dd = dscr_fn(blk_out[65:2], ds);
      ds = dd[57:0];
      if (e_ena) begin
        chk("hdr", 66'(e_hdr), 66'(blk_out[1:0]));
        chk("payload", 66'(e_din), 66'(dd[121:58]));
      end
    end
    if (r) ds = '1;
  endtask

  // Present the held word if any, else optionally a fresh one.
  task automatic drive(input logic r, input bit want, input bit rnd_ctrl);
    logic v;
    if (want && !have_word) begin
      w_data    = {$urandom, $urandom};
      w_ctrl    = rnd_ctrl ? 1'($urandom_range(0, 1)) : 1'b0;
      have_word = 1;
    end
    v = have_word;
    step(r, v, v ? w_ctrl : 1'($urandom_range(0, 1)), v ? w_data : {$urandom, $urandom});
    if (last_xfer) have_word = 0;
  endtask

  initial begin
    int n_xfer, n_gap, last_gap, n_idle, k;
    sclr = 1'b1; tx_valid = 1'b0; tx_ctrl = 1'b0; tx_data = '0;
    ds = '1;
    @(posedge clk);
    #1;

    // Reset with a word presented: it must not be accepted.
    have_word = 1; w_data = 64'h0123_4567_89ab_cdef; w_ctrl = 1'b0;
    drive(1'b1, 1, 0);
    drive(1'b1, 1, 0);
    chk("word_kept_in_reset", 66'd1, 66'(have_word));

    // INIT idles then continuous data over 330 RUN cycles.
    n_xfer = 0; n_gap = 0; last_gap = -1;
    for (int i = 0; i < INIT_IDLES + 330; i++) begin
      drive(1'b0, 1, 0);
      if (i >= INIT_IDLES) begin
        if (last_xfer) n_xfer++;
        if (!obs_rdy) begin
          n_gap++;
          if (last_gap >= 0) chk("gap_spacing", 66'(GAP_PERIOD), 66'(i - last_gap));
          last_gap = i;
        end
      end
    end
    chk("xfer_count", 66'd320, 66'(n_xfer));
    chk("gap_count", 66'd10, 66'(n_gap));

    // Three idle insertions on non-gap cycles, then a control word.
    for (k = 0; k < 5 && have_word; k++) drive(1'b0, 0, 0);
    chk("drain", 66'd0, 66'(have_word));
    n_idle = 0;
    for (int i = 0; i < 3; i++) begin
      if (gap_next()) drive(1'b0, 0, 0);
      drive(1'b0, 0, 0);
      n_idle += int'(idle_ins);
    end
    chk("idle_cnt", 66'd3, 66'(n_idle));
    have_word = 1; w_data = {$urandom, $urandom}; w_ctrl = 1'b1;
    for (k = 0; k < 3 && have_word; k++) drive(1'b0, 1, 0);
    chk("ctrl_xfer", 66'd0, 66'(have_word));

    // Random traffic.
    for (int i = 0; i < 300; i++) drive(1'b0, $urandom_range(0, 3) != 0, 1);

    // Word raised exactly on a gap cycle is held and sent once afterwards.
    for (k = 0; k < 5 && have_word; k++) drive(1'b0, 0, 0);
    for (k = 0; k < 40 && !gap_next(); k++) drive(1'b0, 0, 0);
    chk("gap_found", 66'd1, 66'(gap_next()));
    drive(1'b0, 1, 1);
    chk("gap_not_taken", 66'd1, 66'(have_word));
    drive(1'b0, 1, 1);
    chk("held_taken", 66'd1, 66'(last_xfer));
    drive(1'b0, 0, 0);
    drive(1'b0, 0, 0);

    // Mid-stream one-cycle reset, then traffic resumes through fresh INIT idles.
    for (int i = 0; i < 5; i++) drive(1'b0, 1, 1);
    drive(1'b1, 1, 1);
    for (int i = 0; i < 45; i++) drive(1'b0, $urandom_range(0, 3) != 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
